// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared opcodes, encodings and control bundle for uc_irq
//
// Purpose : opcode localparams, ALU operation codes, WD3 source encodings
//           and the control-bundle struct passed from uc_decoder to uc_irq.
// Ports   : none (package).
package uc_pkg;

  localparam logic [5:0] OP_IN   = 6'b110000;
  localparam logic [5:0] OP_OUT  = 6'b110001;
  localparam logic [5:0] OP_PUSH = 6'b110010;
  localparam logic [5:0] OP_POP  = 6'b110011;
  localparam logic [5:0] OP_J    = 6'b110100;
  localparam logic [5:0] OP_JZ   = 6'b110101;
  localparam logic [5:0] OP_JNZ  = 6'b110110;
  localparam logic [5:0] OP_NOP  = 6'b110111;
  localparam logic [5:0] OP_JAL  = 6'b111000;
  localparam logic [5:0] OP_RET  = 6'b111001;
  localparam logic [5:0] OP_RETI = 6'b111010;
  localparam logic [5:0] OP_EI   = 6'b111011;
  localparam logic [5:0] OP_DI   = 6'b111100;

  // ALU operation codes carried directly in opcode[4:2]
  typedef enum logic [2:0] {
    ALU_OP0 = 3'd0,
    ALU_OP1 = 3'd1,
    ALU_OP2 = 3'd2,
    ALU_OP3 = 3'd3,
    ALU_OP4 = 3'd4,
    ALU_OP5 = 3'd5,
    ALU_OP6 = 3'd6,
    ALU_OP7 = 3'd7
  } alu_op_e;

  localparam logic [1:0] SEL_ALU   = 2'b00;
  localparam logic [1:0] SEL_PORT  = 2'b01;
  localparam logic [1:0] SEL_STACK = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  typedef struct packed {
    logic       s_inc;
    logic       we3;
    logic       wez;
    alu_op_e    op_alu;
    logic [1:0] sel_inputs;
    logic       we_port;
    logic       we_stack_data;
    logic       pushpop;
    logic       we_stack;
    logic       jalret;
    logic       is_cf;    // control-flow opcode: interrupt entry is deferred
    logic       is_reti;
    logic       is_ei;
    logic       is_di;
  } ctrl_t;

endpackage

// File: rtl/uc_decoder.sv
// rtl/uc_decoder.sv - combinational opcode/z to control-bundle decoder
//
// Purpose : maps the 6-bit opcode and registered zero flag to datapath
//           controls plus classification flags used by the interrupt logic.
//           RETI always decodes with RET's datapath effects.
// Ports   : i_opcode [5:0] instruction[15:10]
//           i_z            registered zero flag
//           o_ctrl         decoded control bundle (uc_pkg::ctrl_t)
module uc_decoder
  import uc_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic       i_z,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl       = '0;
    o_ctrl.s_inc = 1'b1;
    if (!i_opcode[5]) begin
      o_ctrl.op_alu     = alu_op_e'(i_opcode[4:2]);
      o_ctrl.we3        = 1'b1;
      o_ctrl.wez        = 1'b1;
      o_ctrl.sel_inputs = SEL_ALU;
    end else if (!i_opcode[4]) begin
      o_ctrl.we3        = 1'b1;
      o_ctrl.sel_inputs = SEL_IMM;
    end else begin
      case (i_opcode)
        OP_IN: begin
          o_ctrl.we3        = 1'b1;
          o_ctrl.sel_inputs = SEL_PORT;
        end
        OP_OUT:  o_ctrl.we_port = 1'b1;
        OP_PUSH: begin
          o_ctrl.we_stack_data = 1'b1;
          o_ctrl.pushpop       = 1'b1;
        end
        OP_POP: begin
          o_ctrl.we_stack_data = 1'b1;
          o_ctrl.we3           = 1'b1;
          o_ctrl.sel_inputs    = SEL_STACK;
        end
        OP_J: begin
          o_ctrl.s_inc = 1'b0;
          o_ctrl.is_cf = 1'b1;
        end
        OP_JZ: begin
          o_ctrl.s_inc = !i_z;
          o_ctrl.is_cf = 1'b1;
        end
        OP_JNZ: begin
          o_ctrl.s_inc = i_z;
          o_ctrl.is_cf = 1'b1;
        end
        OP_JAL: begin
          o_ctrl.s_inc    = 1'b0;
          o_ctrl.we_stack = 1'b1;
          o_ctrl.is_cf    = 1'b1;
        end
        OP_RET, OP_RETI: begin
          o_ctrl.s_inc    = 1'b0;
          o_ctrl.we_stack = 1'b1;
          o_ctrl.jalret   = 1'b1;
          o_ctrl.is_cf    = 1'b1;
          o_ctrl.is_reti  = (i_opcode == OP_RETI);
        end
        OP_EI:   o_ctrl.is_ei = 1'b1;
        OP_DI:   o_ctrl.is_di = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uc_irq.sv
// rtl/uc_irq.sv - control unit with interrupt entry/return sequencing
//
// Purpose : decodes the opcode into datapath controls and, when UC_IRQ_EN is
//           defined, samples the interrupt request, redirects the PC to the
//           exception vector at eligible boundaries and pulses s_finished on
//           RETI. Without UC_IRQ_EN the interrupt state is tied off.
// Ports   : i_clk, i_reset (async, active high), i_opcode[5:0], i_z,
//           i_s_interruption; o_s_inc, o_we3, o_wez, o_op_alu[2:0],
//           o_sel_inputs[1:0], o_s_we_port, o_s_we_stack_data, o_s_pushpop,
//           o_s_we_stack, o_s_jalret, o_s_use_interr, o_s_finished,
//           o_irq_active.
// Macro   : UC_IRQ_EN enables the interrupt logic.
module uc_irq
  import uc_pkg::*;
#(
  parameter int VEC_DEFER = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic       i_z,
  input  logic       i_s_interruption,
  output logic       o_s_inc,
  output logic       o_we3,
  output logic       o_wez,
  output logic [2:0] o_op_alu,
  output logic [1:0] o_sel_inputs,
  output logic       o_s_we_port,
  output logic       o_s_we_stack_data,
  output logic       o_s_pushpop,
  output logic       o_s_we_stack,
  output logic       o_s_jalret,
  output logic       o_s_use_interr,
  output logic       o_s_finished,
  output logic       o_irq_active
);

  generate
    if (VEC_DEFER != 1) begin : g_bad_vec_defer
      $error("uc_irq: only VEC_DEFER = 1 is supported");
    end
  endgenerate

  ctrl_t w_dec;
  logic  w_enter;
  logic  w_reti;
  logic  r_irq_active;

  uc_decoder u_decoder (
    .i_opcode (i_opcode),
    .i_z      (i_z),
    .o_ctrl   (w_dec)
  );

`ifdef UC_IRQ_EN
  logic r_irq_req;
  logic r_ie;

  // RETI is a control-flow opcode, so entry and return never coincide.
  assign w_enter = r_irq_req & r_ie & ~r_irq_active & ~w_dec.is_cf;
  assign w_reti  = w_dec.is_reti;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_irq_req    <= 1'b0;
      r_ie         <= 1'b0;
      r_irq_active <= 1'b0;
    end else begin
      r_irq_req <= i_s_interruption;
      if (w_dec.is_ei) begin
        r_ie <= 1'b1;
      end else if (w_dec.is_di) begin
        r_ie <= 1'b0;
      end
      if (w_enter) begin
        r_irq_active <= 1'b1;
      end else if (w_reti) begin
        r_irq_active <= 1'b0;
      end
    end
  end
`else
  logic w_unused;

  assign w_enter      = 1'b0;
  assign w_reti       = 1'b0;
  assign r_irq_active = 1'b0;
  assign w_unused     = ^{i_clk, i_s_interruption, w_dec.is_cf, w_dec.is_reti,
                          w_dec.is_ei, w_dec.is_di};
`endif

  always_comb begin
    o_s_inc           = w_dec.s_inc;
    o_we3             = w_dec.we3;
    o_wez             = w_dec.wez;
    o_op_alu          = w_dec.op_alu;
    o_sel_inputs      = w_dec.sel_inputs;
    o_s_we_port       = w_dec.we_port;
    o_s_we_stack_data = w_dec.we_stack_data;
    o_s_pushpop       = w_dec.pushpop;
    o_s_we_stack      = w_dec.we_stack;
    o_s_jalret        = w_dec.jalret;
    o_s_use_interr    = 1'b0;
    o_s_finished      = w_reti;
    // Entry keeps the instruction's data effects but overrides the PC path:
    // push PC+1 on the return stack and jump to the vector.
    if (w_enter) begin
      o_s_inc        = 1'b0;
      o_s_use_interr = 1'b1;
      o_s_we_stack   = 1'b1;
      o_s_jalret     = 1'b0;
    end
    if (i_reset) begin
      o_we3             = 1'b0;
      o_wez             = 1'b0;
      o_op_alu          = 3'd0;
      o_sel_inputs      = SEL_ALU;
      o_s_we_port       = 1'b0;
      o_s_we_stack_data = 1'b0;
      o_s_pushpop       = 1'b0;
      o_s_we_stack      = 1'b0;
      o_s_jalret        = 1'b0;
      o_s_use_interr    = 1'b0;
      o_s_finished      = 1'b0;
      o_s_inc           = 1'b1;
    end
  end

  assign o_irq_active = r_irq_active;

endmodule
